// File: rtl/quad_step_decoder.sv
// quad_step_decoder: turns two asynchronous quadrature lines into clean,
// mutually exclusive single-cycle up/down step pulses for the counter.
// Pipeline: 2-flop sync -> per-line debounce -> Gray decode -> output regs.
// Optional: define QDEC_ERR_EN to add err pulse and saturating err_cnt.
// COUNT_MODE must be 4 (x4) or 1 (x1); any value other than 1 decodes as x4.
module quad_step_decoder #(
  parameter int FILTER_LEN = 4,
  parameter int COUNT_MODE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       enable,
  output logic       up,
  output logic       down
`ifdef QDEC_ERR_EN
  ,
  output logic       err,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [7:0] LAST = 8'(FILTER_LEN - 1);

  // Bit 1 carries line A, bit 0 line B, so filt_q is directly {fa,fb}.
  logic [1:0]      s1_q, s1_d, s2_q, s2_d;
  logic [1:0]      filt_q, filt_d;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic [1:0]      prev_q, prev_d;
  logic [1:0]      prime_q, prime_d;
  logic            up_q, up_d, down_q, down_d;
  logic            primed, step_fwd, step_rev, illegal;
`ifdef QDEC_ERR_EN
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
`endif

  assign primed = (prime_q == 2'd3);

  // Sync, prime and debounce next-state; while priming the filter and
  // prev simply follow the synchronised level so a resting non-00
  // encoder does not look like motion.
  always_comb begin
    s1_d    = {enc_a, enc_b};
    s2_d    = s1_q;
    prime_d = primed ? prime_q : prime_q + 2'd1;
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    if (!primed) begin
      filt_d = s2_q;
      cnt_d  = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == filt_q[i]) begin
          cnt_d[i] = 8'd0;
        end else if (cnt_q[i] == LAST) begin
          filt_d[i] = s2_q[i];
          cnt_d[i]  = 8'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
    prev_d = primed ? filt_q : s2_q;
  end

  // Gray decode of prev -> cur; a two-bit change is illegal and ignored.
  always_comb begin
    step_fwd = 1'b0;
    step_rev = 1'b0;
    illegal  = ((prev_q ^ filt_q) == 2'b11);
    if (COUNT_MODE == 1) begin
      step_fwd = (prev_q == 2'b10) && (filt_q == 2'b00);
      step_rev = (prev_q == 2'b01) && (filt_q == 2'b00);
    end else begin
      case ({prev_q, filt_q})
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_fwd = 1'b1;
        4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step_rev = 1'b1;
        default: ;
      endcase
    end
    up_d   = primed && enable && step_fwd;
    down_d = primed && enable && step_rev;
  end

`ifdef QDEC_ERR_EN
  // Error pulse ignores enable; the counter sticks at 255.
  always_comb begin
    err_d     = primed && illegal;
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'd255)) err_cnt_d = err_cnt_q + 8'd1;
  end
`endif

  // State registers; reset clears the whole pipeline and re-arms priming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      prime_q   <= '0;
      filt_q    <= '0;
      cnt_q     <= '0;
      prev_q    <= '0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
`ifdef QDEC_ERR_EN
      err_q     <= 1'b0;
      err_cnt_q <= '0;
`endif
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      prime_q   <= prime_d;
      filt_q    <= filt_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      up_q      <= up_d;
      down_q    <= down_d;
`ifdef QDEC_ERR_EN
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign up      = up_q;
  assign down    = down_q;
`ifdef QDEC_ERR_EN
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: an x4 instance and an x1 instance
// share stimulus; a negedge monitor tallies pulse cycles and rising edges.
module tb_quad_step_decoder;

  logic clk = 1'b0;
  logic rst, enc_a, enc_b, enable;
  logic up, down, m1_up, m1_down;
`ifdef QDEC_ERR_EN
  logic       err, m1_err;
  logic [7:0] err_cnt, m1_err_cnt;
`endif

  always #5 clk = ~clk;

  quad_step_decoder #(.FILTER_LEN(4), .COUNT_MODE(4)) dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enable(enable),
    .up(up), .down(down)
`ifdef QDEC_ERR_EN
    , .err(err), .err_cnt(err_cnt)
`endif
  );

  quad_step_decoder #(.FILTER_LEN(4), .COUNT_MODE(1)) dut_x1 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enable(enable),
    .up(m1_up), .down(m1_down)
`ifdef QDEC_ERR_EN
    , .err(m1_err), .err_cnt(m1_err_cnt)
`endif
  );

  // tallies: 0 up cycles, 1 up pulses, 2 down cycles, 3 down pulses,
  // 4..7 same for x1 instance, 8 err cycles, 9 err pulses, 10 up&down
  int tot [11];
  int base[11];
  logic up_l = 0, dn_l = 0, m1u_l = 0, m1d_l = 0, err_l = 0;
  int total = 0, bad = 0;

  initial for (int i = 0; i < 11; i++) tot[i] = 0;

  always @(negedge clk) begin
    if (up) tot[0]++;
    if (up && !up_l) tot[1]++;
    if (down) tot[2]++;
    if (down && !dn_l) tot[3]++;
    if (m1_up) tot[4]++;
    if (m1_up && !m1u_l) tot[5]++;
    if (m1_down) tot[6]++;
    if (m1_down && !m1d_l) tot[7]++;
    if (up && down) tot[10]++;
    if (m1_up && m1_down) tot[10]++;
    up_l = up; dn_l = down; m1u_l = m1_up; m1d_l = m1_down;
`ifdef QDEC_ERR_EN
    if (err) tot[8]++;
    if (err && !err_l) tot[9]++;
    err_l = err;
`endif
  end

  task automatic snap();
    for (int i = 0; i < 11; i++) base[i] = tot[i];
  endtask

  function automatic int dlt(int i);
    return tot[i] - base[i];
  endfunction

  task automatic chk(string tag, int got, int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic move(logic a, logic b, int n);
    @(negedge clk);
    enc_a = a;
    enc_b = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enc_a = 1'b1; enc_b = 1'b1; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_up", int'(up), 0);
    chk("rst_down", int'(down), 0);
`ifdef QDEC_ERR_EN
    chk("rst_err", int'(err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
`endif

    // resting at 11 through reset release: priming must hide it
    snap();
    @(negedge clk) rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("idle11_up", dlt(0), 0);
    chk("idle11_down", dlt(2), 0);
`ifdef QDEC_ERR_EN
    chk("idle11_err", dlt(8), 0);
`endif

    // restart from 00
    @(negedge clk) begin rst = 1'b1; enc_a = 1'b0; enc_b = 1'b0; end
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);

    // forward 00->01->11->10->00, latency on the first step
    snap();
    @(negedge clk) enc_b = 1'b1;
    @(posedge clk);                       // edge 0
    repeat (5) @(posedge clk);
    #1 chk("lat_edge5", int'(up), 0);
    @(posedge clk);
    #1 chk("lat_edge6", int'(up), 1);
    @(posedge clk);
    #1 chk("width_edge7", int'(up), 0);
    repeat (15) @(posedge clk);
    move(1, 1, 20);
    move(1, 0, 20);
    move(0, 0, 20);
    chk("fwd_up_pulses", dlt(1), 4);
    chk("fwd_up_cycles", dlt(0), 4);
    chk("fwd_down", dlt(2), 0);
    chk("fwd_x1_up", dlt(5), 1);
    chk("fwd_x1_down", dlt(6), 0);

    // reverse 00->10->11->01->00
    snap();
    move(1, 0, 20);
    move(1, 1, 20);
    move(0, 1, 20);
    move(0, 0, 20);
    chk("rev_down_pulses", dlt(3), 4);
    chk("rev_down_cycles", dlt(2), 4);
    chk("rev_up", dlt(0), 0);
    chk("rev_x1_down_pulses", dlt(7), 1);
    chk("rev_x1_down_cycles", dlt(6), 1);
    chk("rev_x1_up", dlt(4), 0);

    // glitch on A from 01: 3 cycles rejected, 4 cycles accepted
    move(0, 1, 20);
    snap();
    @(negedge clk) enc_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) enc_a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("glitch3_up", dlt(0), 0);
    chk("glitch3_down", dlt(2), 0);
    snap();
    @(negedge clk) enc_a = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) enc_a = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("hold4_up", dlt(1), 1);
    chk("hold4_down_back", dlt(3), 1);

    // enable low drops the step for good
    snap();
    @(negedge clk) enable = 1'b0;
    move(1, 1, 20);
    @(negedge clk) enable = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("en_off_up", dlt(0), 0);
    chk("en_off_down", dlt(2), 0);
    snap();
    move(1, 0, 20);
    chk("en_on_up", dlt(1), 1);
    move(0, 0, 20);

    // reset while a pulse is high
    @(negedge clk) enc_b = 1'b1;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1 chk("midrst_pre_up", int'(up), 1);
    #2 rst = 1'b1;
    #1 chk("midrst_up", int'(up), 0);
    @(negedge clk) rst = 1'b0;
    snap();
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_after_up", dlt(0), 0);
    chk("midrst_after_down", dlt(2), 0);

`ifdef QDEC_ERR_EN
    move(0, 0, 20);
    snap();
    for (int k = 0; k < 150; k++) begin
      move(1, 1, 10);
      move(0, 0, 10);
    end
    chk("err_pulses", dlt(9), 300);
    chk("err_cycles", dlt(8), 300);
    chk("err_cnt_sat", int'(err_cnt), 255);
    chk("err_up", dlt(0), 0);
    chk("err_down", dlt(2), 0);
    move(1, 1, 3);
    #2 rst = 1'b1;
    #1 chk("err_cnt_rst", int'(err_cnt), 0);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
`endif

    #1 chk("never_both", tot[10], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
